subtractor_serial: RTL and testbench

Bit-serial two's-complement subtractor computing `a - b` over `WIDTH` cycles, LSB first, using a single one-bit full-subtractor cell and a registered borrow. It is the inverse arithmetic operation to the team's ripple adders in the combinational arithmetic set. It is the sequential, area-minimal subtraction block used where latency is acceptable. A start/done handshake lets a controller issue one operation at a time.

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/full_subtractor.sv | 13 +
 rtl/subtractor_serial.sv | 102 ++++++++++
 tb/tb_subtractor_serial.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the counter-width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Wide enough to hold the values 0..width without wrapping.
    function automatic int CNT_W(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with the borrow returned on bout.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial a - b, LSB first, one bit per cycle through a single full-subtractor cell.
// state    | meaning
// ST_IDLE  | waiting for start
// ST_SHIFT | one result bit per cycle, WIDTH cycles
// ST_DONE  | publish diff/borrow_out, may accept the next start
module subtractor_serial
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             br_next;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Result bits enter at the MSB so the first (LSB) bit ends at position 0.
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    diff       <= res_sr;
                    borrow_out <= br;
                    done       <= 1'b1;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial at WIDTH = 4: vector table, exhaustive sweep,
// and hand-written sequences for busy-start, back-to-back and mid-operation reset.
module tb_subtractor_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_cmp = 0;
    int n_bad = 0;

    subtractor_serial #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_diff;
        logic         exp_bo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One operation from idle; operands are scrambled right after acceptance.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb, input bit timing,
                          input string tag);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ta; b = ~tb_v;
        if (timing) check($sformatf("%s busy@0", tag), 32'(busy), 32'(1));
        for (int k = 1; k <= W + 2; k++) begin
            @(posedge clk); #1;
            if (timing) begin
                check($sformatf("%s busy@%0d", tag, k), 32'(busy), 32'(k < W));
                check($sformatf("%s done@%0d", tag, k), 32'(done), 32'(k == W + 1));
            end
            if (k == W + 1) begin
                check($sformatf("%s diff", tag), 32'(diff), 32'(ed));
                check($sformatf("%s borrow", tag), 32'(borrow_out), 32'(eb));
            end
        end
        if (timing) check($sformatf("%s diff_hold", tag), 32'(diff), 32'(ed));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_done;
        logic [W-1:0] ea;
        logic [W-1:0] eb;

        vecs[0] = '{4'd5,  4'd3,  4'd2,  1'b0};
        vecs[1] = '{4'd3,  4'd5,  4'd14, 1'b1};
        vecs[2] = '{4'd0,  4'd1,  4'd15, 1'b1};
        vecs[3] = '{4'd15, 4'd15, 4'd0,  1'b0};
        vecs[4] = '{4'd15, 4'd0,  4'd15, 1'b0};
        vecs[5] = '{4'd0,  4'd15, 4'd1,  1'b1};
        vecs[6] = '{4'd9,  4'd4,  4'd5,  1'b0};
        vecs[7] = '{4'd8,  4'd9,  4'd15, 1'b1};

        // Reset held two cycles with start asserted.
        rst = 1'b1; start = 1'b1; a = 4'd5; b = 4'd3;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("rst busy", 32'(busy), 32'(0));
            check("rst done", 32'(done), 32'(0));
            check("rst diff", 32'(diff), 32'(0));
            check("rst borrow", 32'(borrow_out), 32'(0));
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("post-rst idle busy", 32'(busy), 32'(0));
            check("post-rst idle done", 32'(done), 32'(0));
        end

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_diff, vecs[i].exp_bo, 1'b1,
                   $sformatf("vec%0d", i));

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                ea = W'(x); eb = W'(y);
                run_op(ea, eb, W'(x - y), logic'(x < y), 1'b0,
                       $sformatf("sweep %0d-%0d", x, y));
            end
        end

        // Start while busy: 9 - 4, then 1 - 2 offered at edge 2.
        @(negedge clk);
        a = 4'd9; b = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 2) begin
                a = 4'd1; b = 4'd2; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) n_done++;
            if (k == W + 1) begin
                check("busy-start done@5", 32'(done), 32'(1));
                check("busy-start diff", 32'(diff), 32'(5));
                check("busy-start borrow", 32'(borrow_out), 32'(0));
            end
        end
        check("busy-start done count", 32'(n_done), 32'(1));

        // Back-to-back: start held high, second operands presented in DONE cycle.
        @(negedge clk);
        a = 4'd7; b = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == W) begin
                a = 4'd2; b = 4'd7;
            end
            if (k == W + 1) start = 1'b0;
            check($sformatf("b2b done@%0d", k), 32'(done), 32'(k == 5 || k == 10));
            if (k == 5) begin
                check("b2b diff1", 32'(diff), 32'(5));
                check("b2b borrow1", 32'(borrow_out), 32'(0));
                check("b2b busy@5", 32'(busy), 32'(1));
            end
            if (k == 7) check("b2b diff1 hold", 32'(diff), 32'(5));
            if (k == 10) begin
                check("b2b diff2", 32'(diff), 32'(11));
                check("b2b borrow2", 32'(borrow_out), 32'(1));
            end
        end

        // Mid-operation reset: 12 - 3 aborted at edge 2.
        @(negedge clk);
        a = 4'd12; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'(0));
        check("midrst done", 32'(done), 32'(0));
        check("midrst diff", 32'(diff), 32'(0));
        check("midrst borrow", 32'(borrow_out), 32'(0));
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("midrst no done", 32'(n_done), 32'(0));
        run_op(4'd6, 4'd6, 4'd0, 1'b0, 1'b1, "after-rst 6-6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
